// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss fill engine.
// On a miss it streams one aligned block from pipelined main memory into the
// data array, then writes the tag on the final word. The core is stalled via
// fsm_busy from the miss cycle until that final word.
module cache_fill_fsm #(
   parameter int AWIDTH          = 16,
   parameter int WORDS_PER_BLOCK = 8,
   localparam int OFFW           = $clog2(WORDS_PER_BLOCK)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [AWIDTH-1:0] miss_address,
   output logic              fsm_busy,
   output logic              mem_enable,
   output logic [AWIDTH-1:0] memory_address,
   input  logic              memory_data_valid,
   output logic              write_data_array,
   output logic [OFFW-1:0]   word_offset,
   output logic              write_tag_array
);

   typedef enum logic {
      IDLE,
      FILL
   } state_t;

   // Block size in bytes is 2*WORDS_PER_BLOCK, so the low OFFW+1 address bits
   // select a byte within the block and are dropped to form the block base.
   localparam logic [AWIDTH-1:0] LOW_MASK  = AWIDTH'((1 << (OFFW + 1)) - 1);
   localparam logic [OFFW:0]     BLK_WORDS = (OFFW + 1)'(WORDS_PER_BLOCK);
   localparam logic [OFFW:0]     LAST_WORD = (OFFW + 1)'(WORDS_PER_BLOCK - 1);
   localparam logic [OFFW:0]     CNT_ONE   = (OFFW + 1)'(1);

   state_t            state, state_nxt;
   logic [OFFW:0]     issue_cnt, issue_nxt;
   logic [OFFW:0]     recv_cnt, recv_nxt;
   logic [AWIDTH-1:0] base, base_nxt;

   // State, counters and block base register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         base      <= '0;
      end else begin
         state     <= state_nxt;
         issue_cnt <= issue_nxt;
         recv_cnt  <= recv_nxt;
         base      <= base_nxt;
      end
   end

   // Next-state logic plus request issue and returned-word write strobes.
   always_comb begin
      state_nxt        = state;
      issue_nxt        = issue_cnt;
      recv_nxt         = recv_cnt;
      base_nxt         = base;
      fsm_busy         = 1'b0;
      mem_enable       = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      word_offset      = '0;
      write_tag_array  = 1'b0;
      case (state)
         IDLE: begin
            fsm_busy = miss_detected;
            if (miss_detected) begin
               state_nxt = FILL;
               base_nxt  = miss_address & ~LOW_MASK;
               issue_nxt = '0;
               recv_nxt  = '0;
            end
         end
         FILL: begin
            fsm_busy = 1'b1;
            if (issue_cnt < BLK_WORDS) begin
               mem_enable     = 1'b1;
               memory_address = base + (AWIDTH'(issue_cnt) << 1);
               issue_nxt      = issue_cnt + CNT_ONE;
            end
            if (memory_data_valid) begin
               write_data_array = 1'b1;
               word_offset      = recv_cnt[OFFW-1:0];
               recv_nxt         = recv_cnt + CNT_ONE;
               if (recv_cnt == LAST_WORD) begin
                  write_tag_array = 1'b1;
                  state_nxt       = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
